flash_cmd_sequencer: RTL and testbench
======================================

Name: flash_cmd_sequencer

Overview:
- Parametrised command sequencer that drives the SPI NOR flash controller's parallel interface.
- Runs a self-test:
  - software reset (RSTEN/RST), then write-enable (WREN);
  - page program of a BURST_LEN-byte pattern;
  - program-completion wait;
  - read-back of the same bytes, compared against the pattern.
- Reports pass/fail, a mismatch count and the last byte read; re-runnable on a start pulse.
- Sits between board top level and the flash controller, in the controller's interface clock domain.

Parameters:
- ADDR_W, 22, width of fAddress.
- DATA_W, 8, width of data bus; fixed 8 for current controller.
- BURST_LEN, 4, bytes programmed then read per run (1..256).
- START_ADDR, 22'h0000A0, first flash address of the burst.
- RST_WAIT, 290, idle cycles after RST before the next command.
- PROG_WAIT, 4096, fixed idle cycles after PP when status polling is compiled out.
- SEED, 8'h01, first pattern byte; byte k = SEED + k + runCount (mod 256).

Ports:
- interfaceClk  in  1  controller interface clock, all logic posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a run when idle, ignored otherwise.
- interfaceEnable_n  out  1  low while a command is active.
- fCommand  out  8  opcode: RSTEN 66h, RST 99h, WREN 06h, PP 02h, READ 03h, RDSR 05h.
- fAddress  out  ADDR_W  command address.
- fData_WR  out  DATA_W  byte to program.
- fData_RD  in  DATA_W  byte read from flash.
- RdDataValid  in  1  one-cycle strobe, fData_RD valid.
- WrDataReady  in  1  one-cycle strobe, controller consumed current fData_WR / command.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  registered; 1 if last run had zero mismatches and no timeout.
- errCount  out  9  mismatches in last run, saturating at 511.
- lastRead  out  DATA_W  last byte captured on RdDataValid.

Behaviour:
- Reset values:
  - interfaceEnable_n=1, busy=0, done=0, pass=0, errCount=0, lastRead=0;
  - fCommand=0, fAddress=0, fData_WR=0, runCount=0, state=IDLE.
  - Reset mid-run aborts immediately; no partial-state recovery.
- States: IDLE, RSTEN, RST, RWAIT, WREN, PP, PWAIT, RD, CHECK.
- Command issue rule:
  - Opcode, address and data are set one cycle before enable_n falls.
  - Inputs are stable while enable_n=0.
  - Every command returns enable_n to 1 for at least one cycle before the next.
- RSTEN/RST/WREN: enable_n low until first WrDataReady; high the following cycle.
  - RSTEN→RST→RWAIT (counts RST_WAIT cycles)→WREN→PP.
- PP:
  - fAddress=START_ADDR; fData_WR=pattern byte 0.
  - On each WrDataReady, advance to next byte.
  - After the BURST_LEN-th WrDataReady, drive enable_n=1 next cycle; go to PWAIT.
- PWAIT: counts PROG_WAIT cycles, then RD.
- RD:
  - fCommand=READ, fAddress=START_ADDR.
  - Each RdDataValid: capture lastRead, compare with expected byte k, increment mismatch counter (saturating), k++.
  - After BURST_LEN-th RdDataValid, enable_n=1 next cycle; go to CHECK.
- CHECK, one cycle:
  - Latch errCount and pass.
  - Pulse done, drop busy, runCount++ (8-bit wrap), return to IDLE.
- start accepted in IDLE only: busy=1 the next cycle; errCount/pass hold old values until CHECK.
- Strobes arriving while enable_n=1 are ignored.
  - A WrDataReady coincident with the final byte's count is consumed; no extra byte is sent.
- Pattern arithmetic is mod 2^DATA_W; address never increments (controller auto-increments within burst).

Optional Feature:
- FLASH_SEQ_STATUS_POLL_EN defined:
  - PWAIT is replaced by repeated RDSR commands, each one byte long.
  - Leave PWAIT when status bit0 (WIP) reads 0.
  - Timeout after PROG_WAIT polls forces pass=0 with errCount unchanged; proceeds to RD anyway.
- Undefined: fixed PROG_WAIT cycle wait; RDSR never issued.

Test Plan:
- Reset held, then released → all outputs at reset values; enable_n=1 for 10 cycles with no start.
- start, controller model echoing written bytes, BURST_LEN=4, SEED=01h → PP bytes 01,02,03,04 at A0h; READ captures same; done pulse, pass=1, errCount=0, lastRead=04h.
- Second start → pattern 02..05; runCount effect verified; pass=1.
- Model corrupts read bytes 1 and 3 → errCount=2, pass=0, lastRead=corrupted byte 3.
- reset asserted during PP byte 2 → enable_n=1 same cycle (async); next start runs full sequence from RSTEN.
- FLASH_SEQ_STATUS_POLL_EN, model returns WIP=1 for 3 polls then 0 → exactly 4 RDSR commands, then READ; with WIP stuck at 1 → PROG_WAIT polls, pass=0.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: flash self-test sequencer (RSTEN/RST, WREN, page program, program wait, read-back compare).
// Define FLASH_SEQ_STATUS_POLL_EN to replace the fixed program wait with RDSR polling of the WIP bit.
module flash_cmd_sequencer #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8,
    parameter int BURST_LEN = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = 22'h0000A0,
    parameter int RST_WAIT = 290,
    parameter int PROG_WAIT = 4096,
    parameter logic [DATA_W-1:0] SEED = 8'h01
) (
    input  logic interfaceClk,
    input  logic reset,
    input  logic start,
    output logic interfaceEnable_n,
    output logic [7:0] fCommand,
    output logic [ADDR_W-1:0] fAddress,
    output logic [DATA_W-1:0] fData_WR,
    input  logic [DATA_W-1:0] fData_RD,
    input  logic RdDataValid,
    input  logic WrDataReady,
    output logic busy,
    output logic done,
    output logic pass,
    output logic [8:0] errCount,
    output logic [DATA_W-1:0] lastRead
);
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST = 8'h99;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
`ifdef FLASH_SEQ_STATUS_POLL_EN
    localparam logic [7:0] OP_RDSR = 8'h05;
`endif
    localparam int WAIT_MAX = RST_WAIT > PROG_WAIT ? RST_WAIT : PROG_WAIT;
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_WAIT - 1);
    localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_WAIT - 1);
    localparam logic [8:0] BYTE_LAST = 9'(BURST_LEN - 1);

    typedef enum logic [3:0] {IDLE, RSTEN, RST, RWAIT, WREN, PP, PWAIT, RD, CHECK} stateT;

    stateT state;
    logic [CNT_W-1:0] waitCnt;
    logic [8:0] byteIdx;
    logic [8:0] errAcc;
    logic [7:0] runCount;
    logic timedOut;
    logic [DATA_W-1:0] expByte;

    // Pattern byte for the current burst position; wraps mod 2^DATA_W.
    always_comb expByte = SEED + DATA_W'(byteIdx) + DATA_W'(runCount);

    // In every command state enable_n high means "opcode already set, fall next edge".
    always_ff @(posedge interfaceClk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            interfaceEnable_n <= 1'b1;
            fCommand <= '0;
            fAddress <= '0;
            fData_WR <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            errCount <= '0;
            lastRead <= '0;
            runCount <= '0;
            waitCnt <= '0;
            byteIdx <= '0;
            errAcc <= '0;
            timedOut <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    fCommand <= OP_RSTEN;
                    byteIdx <= '0;
                    errAcc <= '0;
                    timedOut <= 1'b0;
                    state <= RSTEN;
                end
                RSTEN: if (interfaceEnable_n) interfaceEnable_n <= 1'b0;
                else if (WrDataReady) begin
                    interfaceEnable_n <= 1'b1;
                    fCommand <= OP_RST;
                    state <= RST;
                end
                RST: if (interfaceEnable_n) interfaceEnable_n <= 1'b0;
                else if (WrDataReady) begin
                    interfaceEnable_n <= 1'b1;
                    waitCnt <= '0;
                    state <= RWAIT;
                end
                RWAIT: if (waitCnt == RST_LAST) begin
                    fCommand <= OP_WREN;
                    state <= WREN;
                end else waitCnt <= waitCnt + CNT_W'(1);
                WREN: if (interfaceEnable_n) interfaceEnable_n <= 1'b0;
                else if (WrDataReady) begin
                    interfaceEnable_n <= 1'b1;
                    fCommand <= OP_PP;
                    fAddress <= START_ADDR;
                    fData_WR <= expByte;
                    state <= PP;
                end
                PP: if (interfaceEnable_n) interfaceEnable_n <= 1'b0;
                else if (WrDataReady) begin
                    if (byteIdx == BYTE_LAST) begin
                        interfaceEnable_n <= 1'b1;
                        byteIdx <= '0;
                        waitCnt <= '0;
`ifdef FLASH_SEQ_STATUS_POLL_EN
                        fCommand <= OP_RDSR;
`endif
                        state <= PWAIT;
                    end else begin
                        byteIdx <= byteIdx + 9'd1;
                        fData_WR <= expByte + DATA_W'(1);
                    end
                end
`ifdef FLASH_SEQ_STATUS_POLL_EN
                PWAIT: if (interfaceEnable_n) interfaceEnable_n <= 1'b0;
                else if (RdDataValid) begin
                    interfaceEnable_n <= 1'b1;
                    if (!fData_RD[0] || waitCnt == PROG_LAST) begin
                        timedOut <= fData_RD[0];
                        fCommand <= OP_READ;
                        fAddress <= START_ADDR;
                        state <= RD;
                    end else waitCnt <= waitCnt + CNT_W'(1);
                end
`else
                PWAIT: if (waitCnt == PROG_LAST) begin
                    fCommand <= OP_READ;
                    fAddress <= START_ADDR;
                    state <= RD;
                end else waitCnt <= waitCnt + CNT_W'(1);
`endif
                RD: if (interfaceEnable_n) interfaceEnable_n <= 1'b0;
                else if (RdDataValid) begin
                    lastRead <= fData_RD;
                    if (fData_RD != expByte && errAcc != '1) errAcc <= errAcc + 9'd1;
                    if (byteIdx == BYTE_LAST) begin
                        interfaceEnable_n <= 1'b1;
                        state <= CHECK;
                    end else byteIdx <= byteIdx + 9'd1;
                end
                CHECK: begin
                    errCount <= errAcc;
                    pass <= errAcc == '0 && !timedOut;
                    done <= 1'b1;
                    busy <= 1'b0;
                    runCount <= runCount + 8'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: randomized controller model driving flash_cmd_sequencer, checked against the pattern rules.
`timescale 1ns/1ps
module tb_flash_cmd_sequencer;
    localparam int BURST_LEN = 4;
    localparam int RST_WAIT = 290;
    localparam int PROG_WAIT = 4096;
    localparam logic [21:0] START_ADDR = 22'h0000A0;
    localparam logic [7:0] SEED = 8'h01;
    localparam int RUN_LIMIT = 60000;
`ifdef FLASH_SEQ_STATUS_POLL_EN
    localparam logic [63:0] EXP_CMDS = 64'h66_99_06_02_05_03;
    localparam int EXP_NCMD = 6;
`else
    localparam logic [63:0] EXP_CMDS = 64'h66_99_06_02_03;
    localparam int EXP_NCMD = 5;
`endif

    logic interfaceClk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic RdDataValid = 1'b0;
    logic WrDataReady = 1'b0;
    logic [7:0] fData_RD = '0;
    logic interfaceEnable_n, busy, done, pass;
    logic [7:0] fCommand, fData_WR, lastRead;
    logic [21:0] fAddress;
    logic [8:0] errCount;

    int compared = 0;
    int mismatched = 0;

    always #5 interfaceClk = ~interfaceClk;

    flash_cmd_sequencer #(
        .ADDR_W(22), .DATA_W(8), .BURST_LEN(BURST_LEN), .START_ADDR(START_ADDR),
        .RST_WAIT(RST_WAIT), .PROG_WAIT(PROG_WAIT), .SEED(SEED)
    ) dut (
        .interfaceClk(interfaceClk), .reset(reset), .start(start),
        .interfaceEnable_n(interfaceEnable_n), .fCommand(fCommand), .fAddress(fAddress),
        .fData_WR(fData_WR), .fData_RD(fData_RD), .RdDataValid(RdDataValid),
        .WrDataReady(WrDataReady), .busy(busy), .done(done), .pass(pass),
        .errCount(errCount), .lastRead(lastRead)
    );

    logic [7:0] cmdLog[$];
    logic [7:0] ppLog[$];
    logic [3:0] corruptMask = '0;
    logic [7:0] corruptXor = 8'h5A;
    bit noiseOn = 0;
    int protoErr = 0, doneCount = 0, cycle = 0, riseCycle = 0, rstGap = 0, ppGap = 0;
    int rdIdx = 0, rdsrCount = 0, wipPolls = 0, runIdx = 0;
    logic prevEn = 1'b1, prevDone = 1'b0;
    logic [7:0] prevCmd = '0, endedCmd = '0;
    logic [21:0] prevAddr = '0;
    bit gotDone, busyAfterStart, endPass, endBusy, midPass;
    logic [8:0] endErr, midErr;
    logic [7:0] endLast;

    always @(posedge interfaceClk) cycle++;

    // Controller model: logs commands, checks issue protocol, answers strobes with random latency.
    always @(negedge interfaceClk) begin
        WrDataReady = 1'b0;
        RdDataValid = 1'b0;
        if (done) begin
            doneCount++;
            if (prevDone) protoErr++;
        end
        prevDone = done;
        if (prevEn && !interfaceEnable_n) begin
            if (fCommand !== prevCmd) protoErr++;
            if ((fCommand == 8'h02 || fCommand == 8'h03) && fAddress !== START_ADDR) protoErr++;
            if (endedCmd == 8'h99) rstGap = cycle - riseCycle;
            if (endedCmd == 8'h02) ppGap = cycle - riseCycle;
            if (fCommand == 8'h05) rdsrCount++;
            cmdLog.push_back(fCommand);
            rdIdx = 0;
        end else if (!prevEn && !interfaceEnable_n && (fCommand !== prevCmd || fAddress !== prevAddr)) protoErr++;
        if (!prevEn && interfaceEnable_n) begin
            riseCycle = cycle;
            endedCmd = prevCmd;
        end
        if (!reset) begin
            if (!interfaceEnable_n) begin
                if ($urandom_range(0, 2) != 0) begin
                    case (fCommand)
                        8'h02: begin
                            WrDataReady = 1'b1;
                            ppLog.push_back(fData_WR);
                        end
                        8'h03: begin
                            RdDataValid = 1'b1;
                            fData_RD = (rdIdx < ppLog.size()) ? ppLog[rdIdx] : 8'h00;
                            if (rdIdx < 4 && corruptMask[rdIdx]) fData_RD = fData_RD ^ corruptXor;
                            rdIdx++;
                        end
                        8'h05: begin
                            RdDataValid = 1'b1;
                            fData_RD = {7'd0, rdsrCount <= wipPolls};
                        end
                        default: WrDataReady = 1'b1;
                    endcase
                end
            end else if (noiseOn && $urandom_range(0, 3) == 0) begin
                WrDataReady = 1'b1;
                RdDataValid = 1'b1;
                fData_RD = 8'($urandom);
            end
        end
        prevEn = interfaceEnable_n;
        prevCmd = fCommand;
        prevAddr = fAddress;
    end

    function automatic logic [7:0] patByte(input int run, input int k);
        return 8'(int'(SEED) + run + k);
    endfunction

    function automatic logic [63:0] cmdSeq();
        logic [63:0] s = '0;
        foreach (cmdLog[i]) s = {s[55:0], cmdLog[i]};
        return s;
    endfunction

    function automatic logic [31:0] ppSeq();
        logic [31:0] s = '0;
        foreach (ppLog[i]) s = {s[23:0], ppLog[i]};
        return s;
    endfunction

    function automatic logic [31:0] expPp(input int run);
        logic [31:0] s = '0;
        for (int k = 0; k < BURST_LEN; k++) s = {s[23:0], patByte(run, k)};
        return s;
    endfunction

    task automatic do_run(input logic [3:0] cmask, input bit noise, input bit extraStart);
        cmdLog.delete();
        ppLog.delete();
        corruptMask = cmask;
        noiseOn = noise;
        protoErr = 0;
        doneCount = 0;
        rstGap = 0;
        ppGap = 0;
        rdsrCount = 0;
        gotDone = 0;
        @(negedge interfaceClk);
        start = 1'b1;
        @(negedge interfaceClk);
        start = 1'b0;
        busyAfterStart = busy;
        midErr = errCount;
        midPass = pass;
        if (extraStart) begin
            repeat (20) @(negedge interfaceClk);
            start = 1'b1;
            @(negedge interfaceClk);
            start = 1'b0;
        end
        for (int i = 0; i < RUN_LIMIT && !gotDone; i++) begin
            @(negedge interfaceClk);
            #1;
            if (done) begin
                gotDone = 1;
                endPass = pass;
                endErr = errCount;
                endLast = lastRead;
                endBusy = busy;
            end
        end
        repeat (3) @(negedge interfaceClk);
        noiseOn = 0;
    endtask

    task automatic test_reset();
        bit stayedIdle = 1;
        repeat (3) @(negedge interfaceClk);
        compared++;
        if ({interfaceEnable_n, busy, done, pass, errCount, lastRead, fCommand, fAddress, fData_WR} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 22'd0, 8'd0}) begin
            mismatched++;
            $display("FAIL reset_values: got en_n=%b busy=%b done=%b pass=%b err=%0d last=%h cmd=%h addr=%h wr=%h, expected 1 0 0 0 0 00 00 0 00",
                interfaceEnable_n, busy, done, pass, errCount, lastRead, fCommand, fAddress, fData_WR);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge interfaceClk);
            if (interfaceEnable_n !== 1'b1 || busy !== 1'b0) stayedIdle = 0;
        end
        compared++;
        if (!stayedIdle) begin
            mismatched++;
            $display("FAIL idle_after_reset: en_n/busy left idle, expected en_n=1 busy=0 for 10 cycles");
        end
    endtask

    task automatic test_basic_run();
        do_run(4'b0000, 0, 0);
        compared++;
        if (busyAfterStart !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_busy: got %b expected 1", busyAfterStart);
        end
        compared++;
        if (gotDone !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_done: no done within %0d cycles", RUN_LIMIT);
        end
        compared++;
        if (cmdLog.size() != EXP_NCMD || cmdSeq() !== EXP_CMDS) begin
            mismatched++;
            $display("FAIL basic_cmds: got %0d cmds %h expected %0d cmds %h", cmdLog.size(), cmdSeq(), EXP_NCMD, EXP_CMDS);
        end
        compared++;
        if (ppLog.size() != BURST_LEN || ppSeq() !== expPp(runIdx)) begin
            mismatched++;
            $display("FAIL basic_pp_bytes: got %0d bytes %h expected %h", ppLog.size(), ppSeq(), expPp(runIdx));
        end
        compared++;
        if ({endPass, endErr, endLast, endBusy} !== {1'b1, 9'd0, patByte(runIdx, BURST_LEN - 1), 1'b0}) begin
            mismatched++;
            $display("FAIL basic_result: got pass=%b err=%0d last=%h busy=%b expected 1 0 %h 0",
                endPass, endErr, endLast, endBusy, patByte(runIdx, BURST_LEN - 1));
        end
        compared++;
        if (protoErr != 0 || doneCount != 1) begin
            mismatched++;
            $display("FAIL basic_protocol: got %0d violations %0d done pulses expected 0 and 1", protoErr, doneCount);
        end
        compared++;
        if (rstGap < RST_WAIT || rstGap > RST_WAIT + 2) begin
            mismatched++;
            $display("FAIL basic_rst_wait: got %0d idle cycles expected %0d..%0d", rstGap, RST_WAIT, RST_WAIT + 2);
        end
`ifndef FLASH_SEQ_STATUS_POLL_EN
        compared++;
        if (ppGap < PROG_WAIT || ppGap > PROG_WAIT + 2) begin
            mismatched++;
            $display("FAIL basic_prog_wait: got %0d idle cycles expected %0d..%0d", ppGap, PROG_WAIT, PROG_WAIT + 2);
        end
`endif
        runIdx++;
    endtask

    task automatic test_second_run();
        do_run(4'b0000, 0, 0);
        compared++;
        if (ppSeq() !== expPp(runIdx) || ppLog.size() != BURST_LEN) begin
            mismatched++;
            $display("FAIL second_pp_bytes: got %h expected %h", ppSeq(), expPp(runIdx));
        end
        compared++;
        if ({gotDone, endPass, endErr, endLast} !== {1'b1, 1'b1, 9'd0, patByte(runIdx, BURST_LEN - 1)}) begin
            mismatched++;
            $display("FAIL second_result: got done=%b pass=%b err=%0d last=%h expected 1 1 0 %h",
                gotDone, endPass, endErr, endLast, patByte(runIdx, BURST_LEN - 1));
        end
        runIdx++;
    endtask

    task automatic test_corrupt_read();
        corruptXor = 8'($urandom_range(1, 255));
        do_run(4'b1010, 0, 0);
        compared++;
        if ({gotDone, endPass, endErr} !== {1'b1, 1'b0, 9'd2}) begin
            mismatched++;
            $display("FAIL corrupt_result: got done=%b pass=%b err=%0d expected 1 0 2", gotDone, endPass, endErr);
        end
        compared++;
        if (endLast !== (patByte(runIdx, 3) ^ corruptXor)) begin
            mismatched++;
            $display("FAIL corrupt_last_read: got %h expected %h", endLast, patByte(runIdx, 3) ^ corruptXor);
        end
        runIdx++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] m = 4'($urandom_range(0, 15));
        corruptXor = 8'($urandom_range(1, 255));
        do_run(m, 1, 1);
        compared++;
        if ({midPass, midErr} !== {1'b0, 9'd2}) begin
            mismatched++;
            $display("FAIL b2b_held_result: got pass=%b err=%0d during run expected 0 2", midPass, midErr);
        end
        compared++;
        if (cmdLog.size() != EXP_NCMD || doneCount != 1 || protoErr != 0) begin
            mismatched++;
            $display("FAIL b2b_single_run: got %0d cmds %0d done %0d violations expected %0d 1 0",
                cmdLog.size(), doneCount, protoErr, EXP_NCMD);
        end
        compared++;
        if ({gotDone, endErr, endPass} !== {1'b1, 9'($countones(m)), m == 4'd0}) begin
            mismatched++;
            $display("FAIL b2b_result: mask=%b got done=%b err=%0d pass=%b expected 1 %0d %b",
                m, gotDone, endErr, endPass, $countones(m), m == 4'd0);
        end
        compared++;
        if (endLast !== (patByte(runIdx, 3) ^ (m[3] ? corruptXor : 8'h00))) begin
            mismatched++;
            $display("FAIL b2b_last_read: got %h expected %h", endLast, patByte(runIdx, 3) ^ (m[3] ? corruptXor : 8'h00));
        end
        runIdx++;
    endtask

    task automatic test_reset_mid_pp();
        bit reached = 0;
        ppLog.delete();
        corruptMask = '0;
        @(negedge interfaceClk);
        start = 1'b1;
        @(negedge interfaceClk);
        start = 1'b0;
        for (int i = 0; i < RUN_LIMIT && !reached; i++) begin
            @(negedge interfaceClk);
            #2;
            reached = ppLog.size() >= 2 && !interfaceEnable_n && fCommand == 8'h02;
        end
        compared++;
        if (!reached) begin
            mismatched++;
            $display("FAIL midpp_reach: PP byte 2 never reached within %0d cycles", RUN_LIMIT);
        end
        reset = 1'b1;
        #1;
        compared++;
        if ({interfaceEnable_n, busy, done} !== 3'b100) begin
            mismatched++;
            $display("FAIL midpp_async_reset: got en_n=%b busy=%b done=%b expected 1 0 0", interfaceEnable_n, busy, done);
        end
        repeat (2) @(negedge interfaceClk);
        reset = 1'b0;
        runIdx = 0;
        do_run(4'b0000, 0, 0);
        compared++;
        if (cmdLog.size() != EXP_NCMD || cmdSeq() !== EXP_CMDS) begin
            mismatched++;
            $display("FAIL midpp_rerun_cmds: got %0d cmds %h expected %h", cmdLog.size(), cmdSeq(), EXP_CMDS);
        end
        compared++;
        if ({gotDone, endPass, endErr} !== {1'b1, 1'b1, 9'd0} || ppSeq() !== expPp(runIdx)) begin
            mismatched++;
            $display("FAIL midpp_rerun_result: got done=%b pass=%b err=%0d bytes %h expected 1 1 0 %h",
                gotDone, endPass, endErr, ppSeq(), expPp(runIdx));
        end
        runIdx++;
    endtask

`ifdef FLASH_SEQ_STATUS_POLL_EN
    task automatic test_status_poll();
        wipPolls = 3;
        do_run(4'b0000, 0, 0);
        compared++;
        if (rdsrCount != 4 || cmdLog.size() == 0 || cmdLog[cmdLog.size() - 1] !== 8'h03) begin
            mismatched++;
            $display("FAIL poll_count: got %0d RDSR expected 4 followed by READ", rdsrCount);
        end
        compared++;
        if ({gotDone, endPass, endErr} !== {1'b1, 1'b1, 9'd0}) begin
            mismatched++;
            $display("FAIL poll_result: got done=%b pass=%b err=%0d expected 1 1 0", gotDone, endPass, endErr);
        end
        runIdx++;
        wipPolls = 1 << 30;
        do_run(4'b0000, 0, 0);
        compared++;
        if ({gotDone, endPass, endErr} !== {1'b1, 1'b0, 9'd0} || rdsrCount != PROG_WAIT) begin
            mismatched++;
            $display("FAIL poll_timeout: got done=%b pass=%b err=%0d polls=%0d expected 1 0 0 %0d",
                gotDone, endPass, endErr, rdsrCount, PROG_WAIT);
        end
        runIdx++;
        wipPolls = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_second_run();
        test_corrupt_read();
        test_back_to_back();
        test_reset_mid_pp();
`ifdef FLASH_SEQ_STATUS_POLL_EN
        test_status_poll();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
